mux_rr_arbiter: RTL and testbench

- Round-robin arbiter/scheduler that shares the team's 8:1 single-bit mux among 8 requesters.
- Grants one requester at a time and drives the mux selects s2/s1/s0 from the grant index.
- Registers the selected data bit onto a shared output with a valid qualifier.
- Bounds each tenure with a hold limit so no requester can starve the others.

---
 rtl/mux_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares an 8:1 single-bit mux among 8 requesters.
// Each tenure is bounded by MAX_HOLD while others wait; the mux result is registered with a valid flag.
module mux_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [7:0] d,
   output logic [7:0] gnt,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   output logic       out,
   output logic       out_valid
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   // First set bit of vec scanning ptr, ptr+1, ... mod 8; returns {found, index}.
   function automatic logic [3:0] rr_pick(input logic [7:0] vec, input logic [2:0] ptr);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0000;
      for (int i = 7; i >= 0; i--) begin
         idx = ptr + 3'(i);
         if (vec[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   state_t           state_q, state_d;
   logic [2:0]       cur_q, cur_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [7:0]       gnt_q, gnt_d;
   logic             out_q, out_d;
   logic             out_valid_q, out_valid_d;

   logic [7:0] cand_s;
   logic [3:0] pick_s;
   logic       take_s;

   // Candidate vector: the current owner is masked out while it holds the grant.
   always_comb begin
      if (state_q == GRANT) begin
         cand_s = req & ~(8'h01 << cur_q);
      end else begin
         cand_s = req;
      end
      pick_s = rr_pick(cand_s, ptr_q);
   end

   // Next-state logic: release, timeout, uncontested renewal, or plain hold.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      take_s  = 1'b0;
      case (state_q)
         IDLE: begin
            take_s = pick_s[3];
         end
         GRANT: begin
            if (!req[cur_q]) begin
               if (pick_s[3]) begin
                  take_s = 1'b1;
               end else begin
                  state_d = IDLE;
                  hold_d  = {CNT_W{1'b0}};
               end
            end else if (hold_q == HOLD_LAST) begin
               if (pick_s[3]) begin
                  take_s = 1'b1;
               end else begin
                  hold_d = {CNT_W{1'b0}};
               end
            end else begin
               hold_d = hold_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (take_s) begin
         state_d = GRANT;
         cur_d   = pick_s[2:0];
         hold_d  = {CNT_W{1'b0}};
         ptr_d   = pick_s[2:0] + 3'd1;
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Grant and one-cycle output pipeline, derived from the current and next state.
   always_comb begin
      if (state_d == GRANT) begin
         gnt_d = 8'h01 << cur_d;
      end else begin
         gnt_d = 8'h00;
      end
      if (state_q == GRANT) begin
         out_d       = d[cur_q];
         out_valid_d = 1'b1;
      end else begin
         out_d       = 1'b0;
         out_valid_d = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_q       <= 3'd0;
         ptr_q       <= 3'd0;
         hold_q      <= {CNT_W{1'b0}};
         gnt_q       <= 8'h00;
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
         gnt_q       <= gnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign gnt       = gnt_q;
   assign s0        = cur_q[0];
   assign s1        = cur_q[1];
   assign s2        = cur_q[2];
   assign out       = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter (MAX_HOLD=4): vector table plus hand sequences,
// expected values queued at drive time and popped after the clock edge.
module tb_mux_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] d;
   logic [7:0] gnt;
   logic       s0, s1, s2;
   logic       out;
   logic       out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [7:0] d;
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       out;
      logic       ov;
   } vec_t;

   typedef struct {
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       out;
      logic       ov;
   } exp_t;

   exp_t sb_q[$];
   vec_t tbl[$];

   mux_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .d         (d),
      .gnt       (gnt),
      .s0        (s0),
      .s1        (s1),
      .s2        (s2),
      .out       (out),
      .out_valid (out_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] dd,
                       input logic [7:0] eg, input logic [2:0] es, input logic eo,
                       input logic ev, input string nm);
      exp_t e;
      rst = r;
      req = rq;
      d   = dd;
      e.gnt = eg;
      e.sel = es;
      e.out = eo;
      e.ov  = ev;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk({nm, " gnt"}, gnt, e.gnt);
      chk({nm, " sel"}, {5'd0, s2, s1, s0}, {5'd0, e.sel});
      chk({nm, " out"}, {7'd0, out}, {7'd0, e.out});
      chk({nm, " out_valid"}, {7'd0, out_valid}, {7'd0, e.ov});
      chk({nm, " onehot0"}, {7'd0, $onehot0(gnt)}, 8'd1);
   endtask

   initial begin
      rst = 1'b1;
      req = 8'h00;
      d   = 8'h00;

      // reset, then release with all requesting
      tbl.push_back('{1'b1, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'hFF, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'hFE, 8'h00, 8'h02, 3'd1, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 8'h02, 8'h00, 3'd1, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0});
      // single requester 5
      tbl.push_back('{1'b0, 8'h20, 8'h20, 8'h20, 3'd5, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 8'h20, 8'h00, 3'd5, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0});
      // round robin between 7 and 0, back to back
      tbl.push_back('{1'b0, 8'h81, 8'h80, 8'h80, 3'd7, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h01, 8'h80, 8'h01, 3'd0, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h81, 8'h80, 8'h01, 3'd0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 8'h80, 8'h80, 8'h80, 3'd7, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h01, 8'h80, 8'h01, 3'd0, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 8'h80, 8'h00, 3'd0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0});
      // wrap-around: ptr=7 after granting 6, so 0 beats 3
      tbl.push_back('{1'b0, 8'h40, 8'h00, 8'h40, 3'd6, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'h09, 8'h00, 8'h01, 3'd0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 8'h08, 8'h00, 8'h08, 3'd3, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0});
      // timeout: 2 holds for exactly 4 cycles, then 4
      tbl.push_back('{1'b0, 8'h04, 8'h04, 8'h04, 3'd2, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'h14, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h14, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h14, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h14, 8'h04, 8'h10, 3'd4, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 8'h04, 8'h00, 3'd4, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 8'h04, 8'h00, 3'd4, 1'b0, 1'b0});

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].req, tbl[i].d, tbl[i].gnt, tbl[i].sel,
              tbl[i].out, tbl[i].ov, $sformatf("tbl%0d", i));
      end

      // uncontested: grant 2 stays for 20 cycles across hold wraps
      step(1'b0, 8'h04, 8'h04, 8'h04, 3'd2, 1'b0, 1'b0, "solo_first");
      for (int k = 0; k < 19; k++) begin
         step(1'b0, 8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1, $sformatf("solo_hold%0d", k));
      end
      step(1'b0, 8'h00, 8'h04, 8'h00, 3'd2, 1'b1, 1'b1, "solo_drop");
      step(1'b0, 8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0, "solo_idle");

      // reset in the middle of a tenure of 6 at hold=2
      step(1'b0, 8'h40, 8'h40, 8'h40, 3'd6, 1'b0, 1'b0, "r6_grant");
      step(1'b0, 8'h40, 8'h40, 8'h40, 3'd6, 1'b1, 1'b1, "r6_h1");
      step(1'b0, 8'h40, 8'h40, 8'h40, 3'd6, 1'b1, 1'b1, "r6_h2");
      step(1'b1, 8'h40, 8'h40, 8'h00, 3'd0, 1'b0, 1'b0, "r6_rst");
      step(1'b0, 8'h41, 8'h40, 8'h01, 3'd0, 1'b0, 1'b0, "post_rst_pick0");
      step(1'b0, 8'h40, 8'h40, 8'h40, 3'd6, 1'b0, 1'b1, "post_rst_pick6");
      step(1'b0, 8'h00, 8'h40, 8'h00, 3'd6, 1'b1, 1'b1, "post_rst_drop");
      step(1'b0, 8'h00, 8'h00, 8'h00, 3'd6, 1'b0, 1'b0, "post_rst_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
